// File: rtl/arith_pkg.sv
// Shared arithmetic types and the per-bit borrow equations
// used by the subtractor blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Returns {borrow_out, difference} for one bit position.
    function automatic logic [1:0] sub_bit(
        input logic a,
        input logic b,
        input logic bi
    );
        logic d;
        logic bo;
        d  = a ^ b ^ bi;
        bo = (~a & b) | (bi & ~(a ^ b));
        return {bo, d};
    endfunction

endpackage

// File: rtl/borrow_chunk.sv
// N-bit combinational ripple-borrow slice built from the
// shared per-bit borrow function.
module borrow_chunk
    import arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic [N-1:0] d,
    output logic         bo
);

    logic [N:0] br;
    logic [1:0] r;

    always_comb begin
        br    = '0;
        d     = '0;
        r     = '0;
        br[0] = bi;
        for (int i = 0; i < N; i++) begin
            r       = sub_bit(a[i], b[i], br[i]);
            d[i]    = r[0];
            br[i+1] = r[1];
        end
        bo = br[N];
    end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle subtractor D = A - B - Bin, CHUNK bits per clock.
// Define SERIAL_SUB_OVF_EN to add the signed overflow output ovf.
module serial_borrow_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("serial_borrow_subtractor: CHUNK must divide WIDTH");
        end
    endgenerate

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] dif;
    logic             bo;
    logic             last;

    // Constant-index mux keeps the slice select free of variable part-selects.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    borrow_chunk #(
        .N (CHUNK)
    ) u_chunk (
        .a  (a_sl),
        .b  (b_sl),
        .bi (br_q),
        .d  (dif),
        .bo (bo)
    );

    assign last = (idx_q == IDXW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dout_d  = dout_q;
        idx_d   = idx_q;
        br_d    = br_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        dout_d[i*CHUNK +: CHUNK] = dif;
                    end
                end
                br_d = bo;
                if (last) begin
                    idx_d   = '0;
                    bout_d  = bo;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            idx_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = dout_q;
    assign Bout      = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // The final slice always carries the MSB, so dif[CHUNK-1] is D's sign.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == BUSY && last) begin
            ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (dif[CHUNK-1] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
Multi-cycle, parametrised borrow subtractor. Computes D = A - B - Bin over a WIDTH-bit word, CHUNK bits per clock, with the borrow carried between slices in a register. It trades latency for a short borrow chain and is the sequential successor to the 4-bit combinational ripple-borrow subtractor in the arithmetic component library. Valid/ready handshake on both sides.

Parameters:
WIDTH, 16, operand and difference width in bits (>= 1).
CHUNK, 4, bits processed per cycle. 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0; elaboration error otherwise.
NCHUNK, WIDTH/CHUNK, derived local parameter, not overridable.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operands presented.
in_ready  output  1  block can accept operands.
A  input  WIDTH  minuend.
B  input  WIDTH  subtrahend.
Bin  input  1  borrow in.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
D  output  WIDTH  difference, registered.
Bout  output  1  final borrow out, registered.
ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, D=0, Bout=0, ovf=0, slice index=0, internal borrow=0.
- Clock: one clock; reset is asynchronous and active-high.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid is high at a clock edge:
  - capture A, B; borrow register <= Bin; index <= 0; go to BUSY.
- BUSY: in_ready=0, out_valid=0. Each cycle, slice [idx*CHUNK +: CHUNK] is computed from the captured A and B plus the borrow register:
  - per bit: d = a^b^bi; bo = (~a&b) | (bi & ~(a^b)).
  - D slice <= slice difference; borrow register <= slice borrow out; idx++.
  - After the slice with idx == NCHUNK-1: Bout <= final borrow; go to DONE.
- DONE: out_valid=1, in_ready=0. D and Bout are held stable while out_valid=1 and out_ready=0. When out_ready is high at an edge: out_valid <= 0; go to IDLE.
- Latency: accept at edge 0; out_valid is high after edge NCHUNK. Throughput is one result per NCHUNK+2 cycles at best.
- D is visible while BUSY (partial update) but is valid only when out_valid=1.
- Wrap-around: the result is modulo 2^WIDTH. Bout=1 iff A < B + Bin as unsigned values.
- CHUNK == WIDTH: BUSY lasts exactly one cycle.
- Reset asserted mid-operation: the operation is aborted and all state returns to reset values. No result is produced.
- Input changes while BUSY or DONE are ignored, because the operands are captured at accept.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: port ovf exists. It is updated together with Bout at the final slice:
  - ovf = (A[W-1] != B[W-1]) && (D[W-1] != A[W-1]), using captured operands and final D.
  - ovf is held in DONE and reset to 0.
- Undefined: no ovf port and no sign-tracking logic.

Decomposition:
- Shared package arith_pkg contains:
  - enum sub_state_t {IDLE, BUSY, DONE};
  - a function for the per-bit borrow equations, reused by other subtractor blocks.
- One sub-module: borrow_chunk, parameter N.
  - Inputs: a[N-1:0], b[N-1:0], bi. Outputs: d[N-1:0], bo.
  - A purely combinational ripple chain of the per-bit equations, instantiated once in the datapath.

Test Plan:
- WIDTH=8, CHUNK=2; A=0x35, B=0x12, Bin=0 -> after 4 cycles out_valid=1, D=0x23, Bout=0.
- WIDTH=8, CHUNK=2; A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1. A=0x10, B=0x0F, Bin=1 -> D=0x00, Bout=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> D and Bout stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle and in_ready=1.
- Reset mid-BUSY: assert rst after 2 slices -> out_valid=0, D=0, state IDLE. The next operation A=0xAA, B=0x55 gives D=0x55, Bout=0.
- CHUNK=WIDTH=16; A=0x1234, B=0x1235 -> out_valid 1 cycle after accept, D=0xFFFF, Bout=1. Also run a randomized sweep against a reference model A-B-Bin.
- SERIAL_SUB_OVF_EN, WIDTH=8: A=0x80, B=0x01 -> D=0x7F, ovf=1. A=0x7F, B=0x01 -> D=0x7E, ovf=0.
